// File: rtl/isodata_stream_frontend.sv
// Streaming front-end and result back-end for isodata_cluster_multi_iter.
// It collects N points from a valid/ready stream into the core's x/y arrays
// and pulses core_start. It then waits for core_done, latches the K centroids
// and returns them one word per valid/ready handshake.
module isodata_stream_frontend #(
  parameter int N = 5196,
  parameter int K = 10,
  parameter int Q = 32,
  localparam int PTR_W  = $clog2(N + 1),
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1,
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q-1:0]     in_x,
  input  logic [Q-1:0]     in_y,
  input  logic             in_last,
  output logic             core_start,
  input  logic             core_done,
  output logic [Q-1:0]     core_x  [N],
  output logic [Q-1:0]     core_y  [N],
  input  logic [Q-1:0]     core_cx [K],
  input  logic [Q-1:0]     core_cy [K],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q-1:0]     out_x,
  output logic [Q-1:0]     out_y,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             err_short
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_PAD,
    S_KICK,
    S_WAIT,
    S_EMIT
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic               rdy_q;
  logic [Q-1:0]       last_x_q, last_y_q;
  logic [Q-1:0]       x_mem_q [N];
  logic [Q-1:0]       y_mem_q [N];
  logic [Q-1:0]       cx_q [K];
  logic [Q-1:0]       cy_q [K];

  logic               accept;
  logic               emit_hs;
  logic               ptr_at_end;
  logic               idx_at_end;
  logic               mem_we;
  logic [Q-1:0]       wr_x, wr_y;

  assign accept     = in_valid && in_ready;
  assign emit_hs    = out_valid && out_ready;
  assign ptr_at_end = (wr_ptr_q == PTR_W'(N - 1));
  assign idx_at_end = (idx_q == IDX_W'(K - 1));

  // Slots are written either by an accepted sample or by padding with the last sample.
  assign mem_we = accept || (state_q == S_PAD);
  assign wr_x   = (state_q == S_PAD) ? last_x_q : in_x;
  assign wr_y   = (state_q == S_PAD) ? last_y_q : in_y;

  assign core_x    = x_mem_q;
  assign core_y    = y_mem_q;
  assign err_short = err_q;

  // State register plus pointer, emit index, sticky error and ready-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so that every register samples pre-edge values.
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      rdy_q    <= 1'b1;
    end
  end

  // Point arrays and the pad source: written on accept or while padding.
  // NOTE: the point arrays carry no reset; every slot is rewritten before core_start.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      x_mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_x;
      y_mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_y;
    end
    if (accept) begin
      last_x_q <= in_x;
      last_y_q <= in_y;
    end
  end

  // Centroid snapshot, taken on the cycle core_done is seen in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q <= '{default: '0};
      cy_q <= '{default: '0};
    end else if ((state_q == S_WAIT) && core_done) begin
      cx_q <= core_cx;
      cy_q <= core_cy;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path through this block infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (ptr_at_end)   state_d = S_KICK;
          else if (in_last) state_d = S_PAD;
        end
      end
      S_PAD:  if (ptr_at_end) state_d = S_KICK;
      S_KICK: state_d = S_WAIT;
      S_WAIT: if (core_done) state_d = S_EMIT;
      S_EMIT: if (emit_hs && idx_at_end) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Next values of the write pointer, emit index and sticky short-job flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    err_d    = err_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (in_last && !ptr_at_end) err_d = 1'b1;
        end
      end
      S_PAD:  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      S_EMIT: begin
        // The next job always starts filling at slot 0.
        wr_ptr_d = '0;
        if (emit_hs) begin
          if (idx_at_end) begin
            idx_d = '0;
            err_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from the state; data outputs read zero outside EMIT.
  always_comb begin
    in_ready   = (state_q == S_LOAD) && rdy_q;
    core_start = (state_q == S_KICK);
    busy       = (state_q != S_LOAD);
    out_valid  = (state_q == S_EMIT);
    out_last   = (state_q == S_EMIT) && idx_at_end;
    out_idx    = '0;
    out_x      = '0;
    out_y      = '0;
    if (state_q == S_EMIT) begin
      out_idx = idx_q;
      out_x   = cx_q[idx_q];
      out_y   = cy_q[idx_q];
    end
  end

endmodule

// File: tb/tb_isodata_stream_frontend.sv
// Directed bench for isodata_stream_frontend. Outputs are sampled and inputs
// are driven on the falling clock edge. A small core model raises core_done
// 50 cycles after core_start, with centroids cx[j]=j*111 and cy[j]=-j.
module tb_isodata_stream_frontend;

  localparam int N        = 5196;
  localparam int K        = 10;
  localparam int Q        = 32;
  localparam int DONE_LAT = 50;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [Q-1:0]  in_x, in_y;
  logic          in_last;
  logic          core_start;
  logic          core_done;
  logic [Q-1:0]  core_x  [N];
  logic [Q-1:0]  core_y  [N];
  logic [Q-1:0]  core_cx [K];
  logic [Q-1:0]  core_cy [K];
  logic          out_valid;
  logic          out_ready;
  logic [Q-1:0]  out_x, out_y;
  logic [3:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic          err_short;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // Core model state.
  bit kick_pulse = 1'b0;
  bit armed      = 1'b0;
  int cnt        = 0;

  isodata_stream_frontend #(.N(N), .K(K), .Q(Q)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_last    (in_last),
    .core_start (core_start),
    .core_done  (core_done),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_cx    (core_cx),
    .core_cy    (core_cy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .err_short  (err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // One comparison: counts the vector and, on mismatch, the error.
  task automatic check(input bit ok, input string msg);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL %s", msg);
    end
  endtask

  // Core model: done pulse DONE_LAT cycles after start; optional stray pulse during KICK.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (!rst_n) begin
      armed = 1'b0;
      cnt   = 0;
    end else if (armed) begin
      cnt--;
      if (cnt == 0) begin
        core_done = 1'b1;
        armed     = 1'b0;
      end
    end else if (core_start) begin
      armed = 1'b1;
      cnt   = DONE_LAT;
      if (kick_pulse) core_done = 1'b1;
    end
  end

  // Stream n samples back to back: x = i*1000+base, y = -(i*1000+base), in_last on the final one.
  task automatic load_job(input int n, input int base, input bit junk_after);
    int stalls = 0;
    bit early  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (in_ready !== 1'b1) stalls++;
      in_valid = 1'b1;
      in_x     = 32'(i * 1000 + base);
      in_y     = 32'(-(i * 1000 + base));
      in_last  = (i == n - 1);
      @(negedge clk);
      if (core_start && (i != N - 1)) early = 1'b1;
    end
    // Optionally keep offering junk (with in_last) that must never be consumed.
    in_valid = junk_after;
    in_x     = 32'd777;
    in_y     = 32'd888;
    in_last  = junk_after;
    check(stalls == 0 && !early,
          $sformatf("load_stream: stalls=%0d early_start=%0d, required 0 and 0", stalls, early));
  endtask

  // Wait for the centroid stream and take all K words, optionally with out_ready 1,0,0,1,...
  task automatic drain(input bit toggle, input int start_cyc);
    logic [3:0]   pat = 4'b1001;
    logic [Q-1:0] ex, ey;
    logic [3:0]   ei;
    int guard = 0;
    int got   = 0;
    int steps = 0;
    out_ready = 1'b0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(out_valid === 1'b1,
          $sformatf("emit_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, guard));
    if (out_valid !== 1'b1) return;
    check(cyc == start_cyc + DONE_LAT + 1,
          $sformatf("first_word_latency: got %0d cycles after start, required %0d",
                    cyc - start_cyc, DONE_LAT + 1));
    while (got < K && steps < 100) begin
      out_ready = toggle ? pat[steps % 4] : 1'b1;
      ex = 32'(got * 111);
      ey = 32'(-got);
      ei = 4'(got);
      check({out_valid, out_last, in_ready, out_idx, out_x, out_y} ===
            {1'b1, (got == K - 1), 1'b0, ei, ex, ey},
            $sformatf("emit_word%0d: valid=%0b last=%0b in_ready=%0b idx=%0d x=%0d y=%0d, required 1 %0b 0 %0d %0d %0d",
                      got, out_valid, out_last, in_ready, out_idx, $signed(out_x), $signed(out_y),
                      (got == K - 1), ei, $signed(ex), $signed(ey)));
      if (out_ready) got++;
      @(negedge clk);
      steps++;
    end
    out_ready = 1'b0;
    check(steps == (toggle ? 20 : K),
          $sformatf("emit_cycles: K words took %0d cycles, required %0d", steps, toggle ? 20 : K));
    check({out_valid, busy, in_ready, out_last} === 4'b0010,
          $sformatf("emit_end: valid=%0b busy=%0b in_ready=%0b last=%0b, required 0 0 1 0",
                    out_valid, busy, in_ready, out_last));
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check({in_ready, core_start, out_valid, out_last, busy, err_short, out_idx, out_x, out_y} === '0,
          $sformatf("reset_outputs: rdy=%0b st=%0b ov=%0b ol=%0b busy=%0b err=%0b idx=%0d x=%0d y=%0d, required all 0",
                    in_ready, core_start, out_valid, out_last, busy, err_short, out_idx, out_x, out_y));
    rst_n = 1'b1;
    @(negedge clk);
    check({in_ready, busy} === 2'b10,
          $sformatf("reset_release: in_ready=%0b busy=%0b, required 1 0", in_ready, busy));
  endtask

  // Full job with junk offered through WAIT/EMIT; emit with out_ready held high.
  task automatic test_full_load();
    int start_cyc;
    load_job(N, 0, 1'b1);
    start_cyc = cyc;
    check({core_start, in_ready, busy, err_short} === 4'b1010,
          $sformatf("full_kick: start=%0b in_ready=%0b busy=%0b err=%0b, required 1 0 1 0",
                    core_start, in_ready, busy, err_short));
    check(core_x[N-1] === 32'd5195000 && core_y[N-1] === 32'(-5195000),
          $sformatf("full_slot_last: x=%0d y=%0d, required 5195000 -5195000",
                    $signed(core_x[N-1]), $signed(core_y[N-1])));
    check(core_x[0] === 32'd0 && core_x[2500] === 32'd2500000 && core_y[2500] === 32'(-2500000),
          $sformatf("full_slot_mid: x0=%0d x2500=%0d y2500=%0d, required 0 2500000 -2500000",
                    $signed(core_x[0]), $signed(core_x[2500]), $signed(core_y[2500])));
    @(negedge clk);
    check({core_start, in_ready, busy} === 3'b001,
          $sformatf("full_single_pulse: start=%0b in_ready=%0b busy=%0b, required 0 0 1",
                    core_start, in_ready, busy));
    drain(1'b0, start_cyc);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // 100-sample job: err_short, padding, stray done in KICK, stalled emit, restart at slot 0.
  task automatic test_short_job();
    int gap = 0;
    bit leak = 1'b0;
    int start_cyc;
    kick_pulse = 1'b1;
    load_job(100, 5, 1'b0);
    check({err_short, in_ready, core_start, busy} === 4'b1001,
          $sformatf("short_enter_pad: err=%0b in_ready=%0b start=%0b busy=%0b, required 1 0 0 1",
                    err_short, in_ready, core_start, busy));
    while (!core_start && gap < N) begin
      if (in_ready) leak = 1'b1;
      gap++;
      @(negedge clk);
    end
    start_cyc = cyc;
    check(gap == N - 100 && !leak,
          $sformatf("short_pad_cycles: %0d pad cycles (ready_leak=%0b), required %0d and 0",
                    gap, leak, N - 100));
    check(core_x[0] === 32'd5 && core_x[98] === 32'd98005 && core_x[99] === 32'd99005,
          $sformatf("short_slots_loaded: x0=%0d x98=%0d x99=%0d, required 5 98005 99005",
                    $signed(core_x[0]), $signed(core_x[98]), $signed(core_x[99])));
    check(core_x[100] === 32'd99005 && core_x[N-1] === 32'd99005 && core_y[N-1] === 32'(-99005),
          $sformatf("short_slots_padded: x100=%0d x5195=%0d y5195=%0d, required 99005 99005 -99005",
                    $signed(core_x[100]), $signed(core_x[N-1]), $signed(core_y[N-1])));
    check(err_short === 1'b1,
          $sformatf("short_err_sticky: err_short=%0b, required 1", err_short));
    @(negedge clk);
    kick_pulse = 1'b0;
    drain(1'b1, start_cyc);
    check(err_short === 1'b0,
          $sformatf("short_err_clear: err_short=%0b, required 0", err_short));
  endtask

  // Reset during WAIT aborts the job; a fresh full load is needed for the next start.
  task automatic test_reset_in_wait();
    bit stray = 1'b0;
    int start_cyc;
    load_job(N, 3, 1'b0);
    check(core_start === 1'b1,
          $sformatf("rw_kick: core_start=%0b, required 1", core_start));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({busy, out_valid, in_ready, core_start, err_short} === 5'b0,
          $sformatf("rw_async_reset: busy=%0b ov=%0b rdy=%0b st=%0b err=%0b, required all 0",
                    busy, out_valid, in_ready, core_start, err_short));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (core_start || out_valid || busy) stray = 1'b1;
    end
    check(!stray && in_ready === 1'b1,
          $sformatf("rw_idle_after_reset: stray_activity=%0b in_ready=%0b, required 0 1", stray, in_ready));
    load_job(N, 0, 1'b0);
    start_cyc = cyc;
    check({core_start, err_short} === 2'b10,
          $sformatf("rw_fresh_kick: start=%0b err=%0b, required 1 0", core_start, err_short));
    @(negedge clk);
    drain(1'b0, start_cyc);
  endtask

  initial begin
    core_done = 1'b0;
    for (int j = 0; j < K; j++) begin
      core_cx[j] = 32'(j * 111);
      core_cy[j] = 32'(-j);
    end
    test_reset();
    test_full_load();
    test_short_job();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
